// File: rtl/alarm_denetleyici_pkg.sv
// Shared state codes and default parameter values for the alarm controller.
package alarm_pkg;

    localparam logic [1:0] ISINMA = 2'd0;
    localparam logic [1:0] IZLE   = 2'd1;
    localparam logic [1:0] UYARI  = 2'd2;
    localparam logic [1:0] ALARM  = 2'd3;

    localparam int unsigned ORNEK_PERIYOT_VARSAYILAN = 4;
    localparam int unsigned ISINMA_SAYISI_VARSAYILAN = 4;
    localparam int unsigned ESIK_SAYISI_VARSAYILAN   = 3;
    localparam int unsigned SIREN_BOLEN_VARSAYILAN   = 2;

endpackage

// File: rtl/alarm_denetleyici_if.sv
// Panel/datapath-side signals of the alarm controller.
interface alarm_denetleyici_if;

    logic       alarm_cal;
    logic       onay;
    logic       ornek_al;
    logic       alarm_aktif;
    logic       siren;
    logic [1:0] durum;

    modport master (
        output alarm_cal, onay,
        input  ornek_al, alarm_aktif, siren, durum
    );

    modport slave (
        input  alarm_cal, onay,
        output ornek_al, alarm_aktif, siren, durum
    );

endinterface

// File: rtl/alarm_denetleyici_ornek_zamanlayici.sv
// Free-running period counter: registered sample strobe plus the evaluation-cycle flag that follows it.
module ornek_zamanlayici #(
    parameter int unsigned PERIYOT = 4
) (
    input  logic saat,
    input  logic reset,
    output logic ornek_al_o,
    output logic degerlendir_o
);

    localparam int unsigned SW = $clog2(PERIYOT + 1);

    logic [SW-1:0] sayac_q, sayac_d;
    logic          ornek_al_q;
    logic          degerlendir_q;

    always_comb begin
        sayac_d = (sayac_q == SW'(PERIYOT - 1)) ? '0 : sayac_q + SW'(1);
    end

    // Strobe is decoded from the next count so it lines up with the counter's last value.
    always_ff @(posedge saat) begin
        if (reset) begin
            sayac_q       <= '0;
            ornek_al_q    <= 1'b0;
            degerlendir_q <= 1'b0;
        end else begin
            sayac_q       <= sayac_d;
            ornek_al_q    <= (sayac_d == SW'(PERIYOT - 1));
            degerlendir_q <= ornek_al_q;
        end
    end

    assign ornek_al_o    = ornek_al_q;
    assign degerlendir_o = degerlendir_q;

endmodule

// File: rtl/alarm_denetleyici.sv
// Alarm sequencer: warm-up masking, consecutive-sample qualification, latched siren with operator ack.
// Optional silence-on-ack behaviour is enabled by defining ALARM_SESSIZ_EN.
module alarm_denetleyici
    import alarm_pkg::*;
#(
    parameter int unsigned ORNEK_PERIYOT = ORNEK_PERIYOT_VARSAYILAN,
    parameter int unsigned ISINMA_SAYISI = ISINMA_SAYISI_VARSAYILAN,
    parameter int unsigned ESIK_SAYISI   = ESIK_SAYISI_VARSAYILAN,
    parameter int unsigned SIREN_BOLEN   = SIREN_BOLEN_VARSAYILAN
) (
    input logic                saat,
    input logic                reset,
    alarm_denetleyici_if.slave bus
);

    localparam int unsigned AW = $clog2(ESIK_SAYISI + 1);
    localparam int unsigned IW = $clog2(ISINMA_SAYISI + 1);
    localparam int unsigned BW = $clog2(SIREN_BOLEN + 1);

    logic          ornek_al;
    logic          degerlendir;
    logic [1:0]    durum_q, durum_d;
    logic [AW-1:0] ardisik_q, ardisik_d;
    logic [IW-1:0] isinma_q, isinma_d;
    logic [BW-1:0] siren_say_q, siren_say_d;
    logic          son_alarm_q;
    logic          faz_q, faz_d;
    logic          siren_q, siren_d;
    logic          alarm_aktif_q, alarm_aktif_d;
    logic          sessiz_d;
    logic          alarm_deger_c;
    logic          cikis_c;
    logic          giris_c;
`ifdef ALARM_SESSIZ_EN
    logic          sessiz_q;
`endif

    ornek_zamanlayici #(.PERIYOT(ORNEK_PERIYOT)) u_zamanlayici (
        .saat         (saat),
        .reset        (reset),
        .ornek_al_o   (ornek_al),
        .degerlendir_o(degerlendir)
    );

    // Live flag on evaluation cycles, otherwise the last sampled one.
    assign alarm_deger_c = degerlendir ? bus.alarm_cal : son_alarm_q;
    assign cikis_c       = (durum_q == ALARM) && bus.onay && !alarm_deger_c;
    assign giris_c       = (durum_d == ALARM) && (durum_q != ALARM);

    // State register and datapath registers.
    always_ff @(posedge saat) begin
        if (reset) begin
            durum_q       <= ISINMA;
            ardisik_q     <= '0;
            isinma_q      <= '0;
            siren_say_q   <= '0;
            son_alarm_q   <= 1'b0;
            faz_q         <= 1'b0;
            siren_q       <= 1'b0;
            alarm_aktif_q <= 1'b0;
`ifdef ALARM_SESSIZ_EN
            sessiz_q      <= 1'b0;
`endif
        end else begin
            durum_q       <= durum_d;
            ardisik_q     <= ardisik_d;
            isinma_q      <= isinma_d;
            siren_say_q   <= siren_say_d;
            son_alarm_q   <= degerlendir ? bus.alarm_cal : son_alarm_q;
            faz_q         <= faz_d;
            siren_q       <= siren_d;
            alarm_aktif_q <= alarm_aktif_d;
`ifdef ALARM_SESSIZ_EN
            sessiz_q      <= sessiz_d;
`endif
        end
    end

    // Next-state and qualification counters.
    always_comb begin
        durum_d   = durum_q;
        ardisik_d = ardisik_q;
        isinma_d  = isinma_q;
        case (durum_q)
            ISINMA: begin
                if (degerlendir) begin
                    isinma_d = (isinma_q == IW'(ISINMA_SAYISI)) ? isinma_q : isinma_q + IW'(1);
                    if (isinma_q >= IW'(ISINMA_SAYISI - 1)) durum_d = IZLE;
                end
            end
            IZLE: begin
                if (degerlendir && bus.alarm_cal) begin
                    ardisik_d = AW'(1);
                    durum_d   = (ESIK_SAYISI == 1) ? ALARM : UYARI;
                end
            end
            UYARI: begin
                if (degerlendir) begin
                    if (bus.alarm_cal) begin
                        ardisik_d = (ardisik_q == AW'(ESIK_SAYISI)) ? ardisik_q : ardisik_q + AW'(1);
                        if (ardisik_q >= AW'(ESIK_SAYISI - 1)) durum_d = ALARM;
                    end else begin
                        ardisik_d = '0;
                        durum_d   = IZLE;
                    end
                end
            end
            default: begin
                if (cikis_c) begin
                    ardisik_d = '0;
                    durum_d   = IZLE;
                end
            end
        endcase
    end

    // Output register inputs: latched alarm, siren phase and silence.
    always_comb begin
        alarm_aktif_d = (durum_d == ALARM);
        faz_d         = faz_q;
        siren_say_d   = siren_say_q;
`ifdef ALARM_SESSIZ_EN
        sessiz_d      = sessiz_q;
`else
        sessiz_d      = 1'b0;
`endif
        if (giris_c) begin
            faz_d       = 1'b1;
            siren_say_d = '0;
            sessiz_d    = 1'b0;
        end else if (durum_d == ALARM) begin
            if (siren_say_q == BW'(SIREN_BOLEN - 1)) begin
                siren_say_d = '0;
                faz_d       = ~faz_q;
            end else begin
                siren_say_d = siren_say_q + BW'(1);
            end
`ifdef ALARM_SESSIZ_EN
            if (bus.onay && alarm_deger_c) sessiz_d = 1'b1;
`endif
        end else begin
            faz_d       = 1'b0;
            siren_say_d = '0;
            sessiz_d    = 1'b0;
        end
        siren_d = faz_d & ~sessiz_d;
    end

    assign bus.ornek_al    = ornek_al;
    assign bus.alarm_aktif = alarm_aktif_q;
    assign bus.siren       = siren_q;
    assign bus.durum       = durum_q;

endmodule

// File: tb/tb_alarm_denetleyici.sv
// Randomized bench for alarm_denetleyici against a cycle-indexed behavioural model.
module tb_alarm_denetleyici;

    localparam int P = 4;
    localparam int W = 4;
    localparam int T = 3;
    localparam int B = 2;

    logic saat;
    logic reset;

    alarm_denetleyici_if bus ();

    alarm_denetleyici dut (
        .saat (saat),
        .reset(reset),
        .bus  (bus)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    int n_karsilastirma = 0;
    int n_hata          = 0;

    // Model: k is the cycle index since reset release (1 = first free cycle).
    int k;
    int m_durum;
    int m_isinma;
    int m_ardisik;
    int m_son;
    int m_yas;
    int m_sessiz;

    task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
        n_karsilastirma++;
        if (gozlenen != beklenen) begin
            n_hata++;
            $display("FAIL %s at t=%0t k=%0d: got %0d, expected %0d", etiket, $time, k, gozlenen, beklenen);
        end
    endtask

    function automatic int bek_siren();
        if (m_durum != 3 || m_sessiz != 0) return 0;
        return (((m_yas - 1) / B) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic model_sifirla();
        k         = 1;
        m_durum   = 0;
        m_isinma  = 0;
        m_ardisik = 0;
        m_son     = 0;
        m_yas     = 0;
        m_sessiz  = 0;
    endtask

    // Advances the model across one clock edge using the inputs held in the current cycle.
    task automatic model_adim(input int rst, input int cal, input int ack);
        int ev;
        int deger;
        int eski;
        if (rst != 0) begin
            model_sifirla();
            return;
        end
        ev    = (k > 1 && (k - 1) % P == 0) ? 1 : 0;
        deger = (ev != 0) ? cal : m_son;
        eski  = m_durum;
        if (m_durum == 0) begin
            if (ev != 0) begin
                m_isinma++;
                if (m_isinma >= W) m_durum = 1;
            end
        end else if (m_durum == 1) begin
            if (ev != 0 && cal != 0) begin
                m_ardisik = 1;
                m_durum   = (T == 1) ? 3 : 2;
            end
        end else if (m_durum == 2) begin
            if (ev != 0) begin
                if (cal != 0) begin
                    m_ardisik++;
                    if (m_ardisik >= T) m_durum = 3;
                end else begin
                    m_ardisik = 0;
                    m_durum   = 1;
                end
            end
        end else begin
            if (ack != 0 && deger == 0) begin
                m_durum   = 1;
                m_ardisik = 0;
            end else if (ack != 0) begin
`ifdef ALARM_SESSIZ_EN
                m_sessiz = 1;
`endif
            end
        end
        if (ev != 0) m_son = cal;
        if (m_durum == 3) begin
            if (eski != 3) begin
                m_yas    = 1;
                m_sessiz = 0;
            end else begin
                m_yas++;
            end
        end else begin
            m_yas    = 0;
            m_sessiz = 0;
        end
        k++;
    endtask

    task automatic cikislari_denetle();
        kontrol("ornek_al", int'(bus.ornek_al), (k >= 1 && k % P == 0) ? 1 : 0);
        kontrol("durum", int'(bus.durum), m_durum);
        kontrol("alarm_aktif", int'(bus.alarm_aktif), (m_durum == 3) ? 1 : 0);
        kontrol("siren", int'(bus.siren), bek_siren());
    endtask

    initial begin
        int yuzde;
        int r, c, o;
        reset         = 1'b1;
        bus.alarm_cal = 1'b0;
        bus.onay      = 1'b0;
        model_sifirla();
        repeat (2) @(posedge saat);
        #1;
        cikislari_denetle();

        for (int i = 0; i < 6000; i++) begin
            if (i < 30)                 yuzde = 100;
            else if ((i / 250) % 2 != 0) yuzde = 20;
            else                        yuzde = 85;
            r = ($urandom_range(0, 399) == 0) ? 1 : 0;
            if (m_durum == 3 && bek_siren() == 1 && $urandom_range(0, 59) == 0) r = 1;
            if (i < 30) r = 0;
            c = ($urandom_range(0, 99) < yuzde) ? 1 : 0;
            o = (i >= 30 && $urandom_range(0, 3) == 0) ? 1 : 0;
            reset         = r[0];
            bus.alarm_cal = c[0];
            bus.onay      = o[0];
            model_adim(r, c, o);
            @(posedge saat);
            #1;
            cikislari_denetle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_hata);
        $finish;
    end

endmodule
